// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, instruction memory lookup, branch/jump resolution,
// halt (break) detection and retired-instruction counter for the single-cycle core.
// Latency: inst is combinational from pc; the next pc is registered every edge (0-cycle redirect).
// Backpressure: none; one instruction retires per RUN cycle, HALT freezes pc and counter.
// Optional feature: define IFETCH_JR_EN to add the jr / jr_target register-indirect jump.

// Word-addressed instruction memory with asynchronous read and synchronous write.
// Contents are preloaded by the environment from the image named by FILE.
module syncram #(
  parameter string       FILE  = "",
  parameter int          DEPTH = 256,
  parameter logic [31:0] BASE  = 32'h0040_0000
) (
  input  logic        i_clk,
  input  logic        i_cs,
  input  logic        i_oe,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam bit unused_file = (FILE != "");

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_unused_addr;

  // Byte address relative to the image base; the word index wraps modulo DEPTH.
  assign w_off         = i_addr - BASE;
  assign w_idx         = w_off[AW+1:2];
  assign w_unused_addr = ^{w_off[31:AW+2], w_off[1:0]};

  assign o_dout = (i_cs && i_oe) ? r_mem[w_idx] : 32'h0;

  // Write port; unused by the fetch unit but kept so the macro stays generic.
  always_ff @(posedge i_clk) begin
    if (i_cs && i_we) begin
      r_mem[w_idx] <= i_din;
    end
  end

endmodule

module instruction_fetch #(
  parameter string       file       = "",
  parameter logic [31:0] START_ADDR = 32'h0040_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_beq,
  input  logic        i_bne,
  input  logic        i_bgtz,
  input  logic        i_jump,
  input  logic        i_zero,
  input  logic        i_msb,
`ifdef IFETCH_JR_EN
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
`endif
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid,
  output logic        o_halted,
  output logic [31:0] o_inst_count
);

  localparam int IMEM_DEPTH = 256;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst_count;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_cnt_nxt;

  logic [31:0] w_inst;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_redirect_pc;
  logic        w_is_halt;
  logic        w_jr_sel;
  logic [31:0] w_jr_pc;

`ifdef IFETCH_JR_EN
  // Register targets are forced to a word boundary so pc never misaligns.
  assign w_jr_sel = i_jr;
  assign w_jr_pc  = i_jr_target & 32'hFFFF_FFFC;
`else
  assign w_jr_sel = 1'b0;
  assign w_jr_pc  = 32'h0;
`endif

  // Instruction memory is read-only from this unit: always selected, never written.
  syncram #(
    .FILE  (file),
    .DEPTH (IMEM_DEPTH),
    .BASE  (START_ADDR)
  ) u_imem (
    .i_clk  (i_clk),
    .i_cs   (1'b1),
    .i_oe   (1'b1),
    .i_we   (1'b0),
    .i_addr (r_pc),
    .i_din  (32'h0),
    .o_dout (w_inst)
  );

  // Candidate targets, all modulo 2^32.
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{w_inst[15]}}, w_inst[15:0], 2'b00};
  assign w_br_target = w_pc_plus4 + w_br_offset;
  assign w_j_target  = {w_pc_plus4[31:28], w_inst[25:0], 2'b00};

  // break: SPECIAL opcode with funct 0x0D.
  assign w_is_halt = (w_inst[31:26] == 6'd0) && (w_inst[5:0] == 6'b001101);

  // Priority redirect select; a false branch condition falls to pc+4, not to a lower branch.
  always_comb begin
    w_redirect_pc = w_pc_plus4;
    if (w_jr_sel) begin
      w_redirect_pc = w_jr_pc;
    end else if (i_jump) begin
      w_redirect_pc = w_j_target;
    end else if (i_beq) begin
      w_redirect_pc = i_zero ? w_br_target : w_pc_plus4;
    end else if (i_bne) begin
      w_redirect_pc = !i_zero ? w_br_target : w_pc_plus4;
    end else if (i_bgtz) begin
      w_redirect_pc = (!i_zero && !i_msb) ? w_br_target : w_pc_plus4;
    end
  end

  // RUN/HALT next state plus next pc and retired count; HALT holds everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_inst_count;
    case (r_state)
      S_RUN: begin
        if (w_is_halt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt  = w_redirect_pc;
          w_cnt_nxt = r_inst_count + 32'd1;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State, pc and counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_RUN;
      r_pc         <= START_ADDR;
      r_inst_count <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst_count <= w_cnt_nxt;
    end
  end

  assign o_inst       = w_inst;
  assign o_pc         = r_pc;
  assign o_valid      = (r_state == S_RUN);
  assign o_halted     = (r_state == S_HALT);
  assign o_inst_count = r_inst_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized flags/selects
// checked against a behavioural next-pc model computed from the fetch rules.
module tb_instruction_fetch;

  localparam logic [31:0] START = 32'h0040_0000;
  localparam int          DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        beq, bne, bgtz, jump, zero, msb;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] inst, pc, inst_count;
  logic        valid, halted;

  int total;
  int bad;

  logic [31:0] tb_mem [DEPTH];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halted;

  instruction_fetch #(
    .file       (""),
    .START_ADDR (START)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_beq        (beq),
    .i_bne        (bne),
    .i_bgtz       (bgtz),
    .i_jump       (jump),
    .i_zero       (zero),
    .i_msb        (msb),
`ifdef IFETCH_JR_EN
    .i_jr         (jr),
    .i_jr_target  (jr_target),
`endif
    .o_inst       (inst),
    .o_pc         (pc),
    .o_valid      (valid),
    .o_halted     (halted),
    .o_inst_count (inst_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    logic [31:0] widx;
    widx = ((a - START) >> 2) % DEPTH;
    return tb_mem[widx];
  endfunction

  function automatic bit is_break(input logic [31:0] w);
    return (w >> 26) == 0 && (w % 64) == 13;
  endfunction

  // Next pc of a retiring instruction, straight from the fetch rules.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] p, input logic [31:0] w);
    logic [31:0] pc4;
    logic [31:0] br;
    logic [31:0] jt;
    pc4 = p + 4;
    br  = pc4 + 32'($signed(w[15:0])) * 4;
    jt  = (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if (jr)   return jr_target & ~32'd3;
    if (jump) return jt;
    if (beq)  return zero ? br : pc4;
    if (bne)  return !zero ? br : pc4;
    if (bgtz) return (!zero && !msb) ? br : pc4;
    return pc4;
  endfunction

  task automatic load_image();
    for (int i = 0; i < DEPTH; i++) dut.u_imem.r_mem[i] = tb_mem[i];
  endtask

  task automatic fill_image(input bit allow_halt);
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      if (!allow_halt && is_break(w)) w[0] = 1'b0;
      tb_mem[i] = w;
    end
    load_image();
  endtask

  task automatic clear_sel();
    beq = 0; bne = 0; bgtz = 0; jump = 0; zero = 0; msb = 0; jr = 0; jr_target = 0;
  endtask

  // Advance the model with the current inputs, then let the DUT take the same edge.
  task automatic tick();
    if (!rst_n) begin
      m_pc = START; m_cnt = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (is_break(mem_at(m_pc))) begin
        m_halted = 1;
      end else begin
        m_cnt = m_cnt + 1;
        m_pc  = ref_next_pc(m_pc, mem_at(m_pc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_sel();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    fill_image(0);
    do_reset();
    total++; if (pc !== START) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, START); end
    total++; if (inst_count !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", inst_count); end
    total++; if (valid !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL reset_state got valid=%b halted=%b want 1/0", valid, halted); end
    total++; if (inst !== tb_mem[0]) begin bad++; $display("FAIL reset_inst got=%h want=%h", inst, tb_mem[0]); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (pc !== START + 32'(4 * k)) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", k, pc, START + 32'(4 * k)); end
      total++; if (inst_count !== 32'(k)) begin bad++; $display("FAIL seq_count%0d got=%0d want=%0d", k, inst_count, k); end
    end
  endtask

  task automatic test_beq();
    fill_image(0);
    tb_mem[4] = 32'h1000_FFFF;
    load_image();
    do_reset();
    repeat (4) tick();
    total++; if (pc !== 32'h0040_0010) begin bad++; $display("FAIL beq_setup got=%h want=00400010", pc); end
    beq = 1; zero = 1;
    tick();
    total++; if (pc !== 32'h0040_0010) begin bad++; $display("FAIL beq_taken got=%h want=00400010", pc); end
    zero = 0;
    tick();
    total++; if (pc !== 32'h0040_0014) begin bad++; $display("FAIL beq_not_taken got=%h want=00400014", pc); end
    total++; if (inst_count !== 6) begin bad++; $display("FAIL beq_count got=%0d want=6", inst_count); end
    clear_sel();
  endtask

  task automatic test_jump();
    fill_image(0);
    tb_mem[0] = 32'h0810_0008;
    tb_mem[8] = 32'h1C00_0003;
    load_image();
    do_reset();
    jump = 1; beq = 1; zero = 1;
    tick();
    total++; if (pc !== 32'h0040_0020) begin bad++; $display("FAIL jump_over_beq got=%h want=00400020", pc); end
    clear_sel();
  endtask

  task automatic test_bgtz();
    for (int c = 0; c < 2; c++) begin
      do_reset();
      jump = 1;
      tick();
      clear_sel();
      bgtz = 1; zero = 0; msb = (c == 1);
      tick();
      total++;
      if (pc !== ((c == 0) ? 32'h0040_0030 : 32'h0040_0024)) begin
        bad++; $display("FAIL bgtz_msb%0d got=%h want=%h", c, pc, (c == 0) ? 32'h0040_0030 : 32'h0040_0024);
      end
      clear_sel();
    end
  endtask

  task automatic test_halt();
    fill_image(0);
    tb_mem[3] = 32'h0000_000D;
    load_image();
    do_reset();
    repeat (3) tick();
    total++; if (pc !== 32'h0040_000C || halted !== 1'b0) begin bad++; $display("FAIL halt_arrive got pc=%h halted=%b want 0040000c/0", pc, halted); end
    tick();
    total++; if (halted !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL halt_state got halted=%b valid=%b want 1/0", halted, valid); end
    for (int k = 0; k < 5; k++) begin
      {beq, bne, bgtz, jump, zero, msb} = 6'($urandom());
      tick();
      total++; if (pc !== 32'h0040_000C) begin bad++; $display("FAIL halt_pc%0d got=%h want=0040000c", k, pc); end
      total++; if (inst_count !== 3) begin bad++; $display("FAIL halt_count%0d got=%0d want=3", k, inst_count); end
    end
    do_reset();
    total++; if (pc !== START || halted !== 1'b0 || inst_count !== 0) begin
      bad++; $display("FAIL halt_reset got pc=%h halted=%b count=%0d want 00400000/0/0", pc, halted, inst_count);
    end
  endtask

`ifdef IFETCH_JR_EN
  task automatic test_jr();
    fill_image(0);
    do_reset();
    jr = 1; jr_target = 32'h0040_0103; jump = 1;
    tick();
    total++; if (pc !== 32'h0040_0100) begin bad++; $display("FAIL jr_priority got=%h want=00400100", pc); end
    clear_sel();
  endtask
`endif

  task automatic test_random();
    fill_image(1);
    do_reset();
    for (int n = 0; n < 600; n++) begin
      {beq, bne, bgtz, jump, zero, msb} = 6'($urandom());
      if ($urandom_range(0, 3) != 0) {beq, bne, jump} = 3'b000;
`ifdef IFETCH_JR_EN
      jr = ($urandom_range(0, 7) == 0);
      jr_target = START + 32'($urandom_range(0, 4 * DEPTH - 1));
`endif
      rst_n = ($urandom_range(0, 39) != 0);
      tick();
      total++;
      if (pc !== m_pc || inst_count !== m_cnt || halted !== m_halted || valid !== !m_halted || inst !== mem_at(m_pc)) begin
        bad++;
        $display("FAIL random_step%0d got pc=%h cnt=%0d halted=%b valid=%b inst=%h want pc=%h cnt=%0d halted=%b inst=%h",
                 n, pc, inst_count, halted, valid, inst, m_pc, m_cnt, m_halted, mem_at(m_pc));
      end
    end
    rst_n = 1;
    clear_sel();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 0;
    m_pc = START; m_cnt = 0; m_halted = 0;
    clear_sel();
    test_reset();
    test_beq();
    test_jump();
    test_bgtz();
    test_halt();
`ifdef IFETCH_JR_EN
    test_jr();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
